// File: rtl/matrix_result_drain_pkg.sv
// Shared widths, element count and FSM encoding for the matrix result drain.
package matrix_result_drain_pkg;

  localparam int unsigned DATA_W_DEF = 21;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned N_ELEM_DEF = 1024;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_result_drain_sync_fifo.sv
// Register-based skid FIFO; wrap-bit pointers tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // On a full FIFO a push is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/matrix_result_drain.sv
// Collects one matrix product's result elements into a skid FIFO and drains them downstream.
module matrix_result_drain
  import matrix_result_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned N_ELEM = N_ELEM_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_ELEM);

  state_t             state, state_next;
  logic [CNT_W-1:0]   in_cnt, in_cnt_next;
  logic [CNT_W-1:0]   out_cnt, out_cnt_next;
  logic               overflow_next;
  logic               done_next;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .push  (push),
    .pop   (pop),
    .wdata ({in_addr, in_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop       = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  // Head is masked while empty so the stale array never shows on the outputs.
  assign out_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign out_addr  = fifo_empty ? '0 : head[ENTRY_W-1:DATA_W];

  // Next-state, counters and flags.
  always_comb begin
    state_next    = state;
    in_cnt_next   = in_cnt;
    out_cnt_next  = out_cnt;
    overflow_next = overflow;
    done_next     = 1'b0;
    push          = 1'b0;
    if (start) begin
      state_next    = COLLECT;
      in_cnt_next   = '0;
      out_cnt_next  = '0;
      overflow_next = 1'b0;
    end else begin
      if (pop && (out_cnt != N_CNT)) out_cnt_next = out_cnt + CNT_W'(1);
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   overflow_next = 1'b1;
            if (in_cnt != N_CNT) in_cnt_next = in_cnt + CNT_W'(1);
          end
          if (in_cnt_next == N_CNT) state_next = DRAIN;
        end
        DRAIN: begin
          if (out_cnt_next == N_CNT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      in_cnt   <= in_cnt_next;
      out_cnt  <= out_cnt_next;
      overflow <= overflow_next;
      done     <= done_next;
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: full runs, overflow, full push/pop, restart, reset, stalls.
module tb_matrix_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [20:0] in_data;
  logic [9:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_data;
  logic [9:0]  out_addr;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  matrix_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_elems(input int first, input int n, input int ready_until);
    for (int i = first; i < first + n; i++) begin
      in_valid = 1'b1;
      in_addr = 10'(i);
      in_data = 21'(i * 3);
      out_ready = (i <= ready_until);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    if ({out_valid, busy, done, overflow, out_data, out_addr} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b o=%b data=%h addr=%h expected all 0",
               out_valid, busy, done, overflow, out_data, out_addr);
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
    checks++;
  endtask

  task automatic test_full_run();
    int done0;
    done0 = done_cnt;
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) begin
        if ({out_valid, out_addr, out_data, done} !== {1'b1, 10'(i - 1), 21'((i - 1) * 3), 1'b0}) begin
          errors++;
          $display("FAIL full_run_elem %0d: got v=%b addr=%0d data=%0d done=%b expected 1 %0d %0d 0",
                   i - 1, out_valid, out_addr, out_data, done, i - 1, (i - 1) * 3);
        end
        checks++;
      end
      in_valid = 1'b1;
      in_addr = 10'(i);
      in_data = 21'(i * 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if ({out_valid, out_addr, out_data, busy} !== {1'b1, 10'd1023, 21'd3069, 1'b1}) begin
      errors++;
      $display("FAIL full_run_last: got v=%b addr=%0d data=%0d busy=%b expected 1 1023 3069 1",
               out_valid, out_addr, out_data, busy);
    end
    checks++;
    @(negedge clk);
    if ({done, busy, out_valid, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL full_run_done: got done=%b busy=%b v=%b ovf=%b expected 1 0 0 0",
               done, busy, out_valid, overflow);
    end
    checks++;
    @(negedge clk);
    if (done !== 1'b0 || done_cnt !== done0 + 1) begin
      errors++;
      $display("FAIL full_run_single_done: got done=%b pulses=%0d expected 0 %0d", done, done_cnt - done0, 1);
    end
    checks++;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_addr = 10'(i);
      in_data = 21'(i * 3);
      @(negedge clk);
      if ({out_valid, out_addr, out_data, overflow} !== {1'b1, 10'd0, 21'd0, (i == 8)}) begin
        errors++;
        $display("FAIL overflow_fill %0d: got v=%b addr=%0d data=%0d ovf=%b expected 1 0 0 %b",
                 i, out_valid, out_addr, out_data, overflow, (i == 8));
      end
      checks++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if ({out_valid, out_addr, out_data} !== {1'b1, 10'(k), 21'(k * 3)}) begin
        errors++;
        $display("FAIL overflow_drain %0d: got v=%b addr=%0d data=%0d expected 1 %0d %0d",
                 k, out_valid, out_addr, out_data, k, k * 3);
      end
      checks++;
      @(negedge clk);
    end
    if ({out_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_dropped: got v=%b ovf=%b expected 0 1", out_valid, overflow);
    end
    checks++;
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    pulse_start();
    if ({out_valid, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL start_clears: got v=%b ovf=%b expected 0 0", out_valid, overflow);
    end
    checks++;
    push_elems(0, 8, -1);
    in_valid = 1'b1;
    in_addr = 10'd8;
    in_data = 21'd24;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    if ({overflow, out_valid, out_addr} !== {1'b0, 1'b1, 10'd1}) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%b v=%b addr=%0d expected 0 1 1", overflow, out_valid, out_addr);
    end
    checks++;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if ({out_valid, out_addr, out_data} !== {1'b1, 10'(k), 21'(k * 3)}) begin
        errors++;
        $display("FAIL full_push_pop_drain %0d: got v=%b addr=%0d data=%0d expected 1 %0d %0d",
                 k, out_valid, out_addr, out_data, k, k * 3);
      end
      checks++;
      @(negedge clk);
    end
    if ({out_valid, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL full_push_pop_occupancy: got v=%b ovf=%b expected 0 0", out_valid, overflow);
    end
    checks++;
    out_ready = 1'b0;
  endtask

  task automatic test_restart();
    int done0;
    out_ready = 1'b1;
    pulse_start();
    push_elems(0, 500, 2000);
    done0 = done_cnt;
    pulse_start();
    if ({out_valid, overflow, busy, done} !== 4'b0010) begin
      errors++;
      $display("FAIL restart_clear: got v=%b ovf=%b busy=%b done=%b expected 0 0 1 0",
               out_valid, overflow, busy, done);
    end
    checks++;
    push_elems(0, 1024, 2000);
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_early_done: got done=%b busy=%b expected 0 1", done, busy);
    end
    checks++;
    @(negedge clk);
    if ({done, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL restart_done: got done=%b ovf=%b expected 1 0", done, overflow);
    end
    checks++;
    @(negedge clk);
    if (done_cnt !== done0 + 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d expected %0d", done_cnt - done0, 1);
    end
    checks++;
  endtask

  task automatic test_reset_mid_drain();
    int done0;
    out_ready = 1'b1;
    pulse_start();
    push_elems(0, 1024, 1019);
    if ({busy, out_valid, out_addr} !== {1'b1, 1'b1, 10'd1019}) begin
      errors++;
      $display("FAIL mid_drain_setup: got busy=%b v=%b addr=%0d expected 1 1 1019", busy, out_valid, out_addr);
    end
    checks++;
    done0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if ({out_valid, busy, done, overflow, out_data, out_addr} !== 35'd0) begin
      errors++;
      $display("FAIL mid_drain_reset: got v=%b b=%b d=%b o=%b data=%h addr=%h expected all 0",
               out_valid, busy, done, overflow, out_data, out_addr);
    end
    checks++;
    in_valid = 1'b1;
    in_addr = 10'd5;
    in_data = 21'd15;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    if ({out_valid, busy} !== 2'b00 || done_cnt !== done0) begin
      errors++;
      $display("FAIL idle_ignores_input: got v=%b busy=%b pulses=%0d expected 0 0 0",
               out_valid, busy, done_cnt - done0);
    end
    checks++;
  endtask

  task automatic test_ready_toggle();
    int done0;
    int exp_addr;
    out_ready = 1'b1;
    pulse_start();
    push_elems(0, 1024, 1019);
    done0 = done_cnt;
    exp_addr = 1019;
    for (int c = 0; c < 20 && exp_addr < 1024; c++) begin
      if ({out_valid, out_addr, out_data, done} !== {1'b1, 10'(exp_addr), 21'(exp_addr * 3), 1'b0}) begin
        errors++;
        $display("FAIL toggle_head c=%0d: got v=%b addr=%0d data=%0d done=%b expected 1 %0d %0d 0",
                 c, out_valid, out_addr, out_data, done, exp_addr, exp_addr * 3);
      end
      checks++;
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (out_ready) exp_addr++;
    end
    out_ready = 1'b0;
    if (exp_addr !== 1024) begin
      errors++;
      $display("FAIL toggle_bound: got next addr %0d expected 1024", exp_addr);
    end
    checks++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL toggle_done: got done=%b busy=%b v=%b expected 1 0 0", done, busy, out_valid);
    end
    checks++;
    repeat (2) @(negedge clk);
    if (done_cnt !== done0 + 1) begin
      errors++;
      $display("FAIL toggle_done_count: got %0d expected %0d", done_cnt - done0, 1);
    end
    checks++;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_addr = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_run();
    test_overflow();
    test_full_push_pop();
    test_restart();
    test_reset_mid_drain();
    test_ready_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
